// File: rtl/barrel_shifter_left_pipe.sv
// barrel_shifter_left_pipe
//   Pipelined left barrel shifter / rotator with valid/ready handshakes on
//   both sides. One 2:1 mux level per register stage, applied in order
//   shift-by-1, shift-by-2, shift-by-4, ... so the pipeline depth equals the
//   shift-amount width SHW = $clog2(WIDTH). Each stage stalls independently,
//   so bubbles are squeezed out even while the output is back-pressured.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      input beat present
//   in_ready   out  1      block accepts a beat this cycle (combinational)
//   in_data    in   WIDTH  operand
//   in_shamt   in   SHW    left shift amount 0..WIDTH-1
//   in_rotate  in   1      1 = rotate left, 0 = logical left (zero fill)
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  shifted/rotated result
//   out_zero   out  1      out_data == 0, registered alongside out_data
module barrel_shifter_left_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_rotate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Stage k (0-based) applies shift-amount bit k, i.e. a shift by 2^k.
    logic             valid_q [SHW];
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   shamt_q [SHW];
    logic             rot_q   [SHW];
    logic             zero_q;

    logic             valid_d [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [SHW-1:0]   shamt_d [SHW];
    logic             rot_d   [SHW];
    logic             zero_d;

    // load[k]: stage k captures its upstream this cycle. load[SHW] is the
    // downstream sink. A stage may load when it is empty or when the stage
    // after it is also moving, which lets bubbles collapse under stall.
    logic [SHW:0]     load;

    always_comb begin
        load[SHW] = out_ready;
        for (int unsigned k = SHW; k > 0; k--) begin
            load[k-1] = !valid_q[k-1] || load[k];
        end
        in_ready = load[0] && !rst;
    end

    always_comb begin
        for (int unsigned k = 0; k < SHW; k++) begin
            if (k == 0) begin
                valid_d[k] = in_valid && in_ready;
                data_d[k]  = in_data;
                shamt_d[k] = in_shamt;
                rot_d[k]   = in_rotate;
            end else begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                shamt_d[k] = shamt_q[k-1];
                rot_d[k]   = rot_q[k-1];
            end
            if (shamt_d[k][k]) begin
                if (rot_d[k]) begin
                    data_d[k] = (data_d[k] << (1 << k)) | (data_d[k] >> (WIDTH - (1 << k)));
                end else begin
                    data_d[k] = data_d[k] << (1 << k);
                end
            end
        end
        // Zero flag is derived from the final stage's input so it lands in
        // the same cycle as the data it describes.
        zero_d = (data_d[SHW-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                rot_q[k]   <= 1'b0;
            end
            zero_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < SHW; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_d[k];
                    data_q[k]  <= data_d[k];
                    shamt_q[k] <= shamt_d[k];
                    rot_q[k]   <= rot_d[k];
                end
            end
            if (load[SHW-1]) begin
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_shifter_left_pipe.sv
// tb_barrel_shifter_left_pipe
//   Self-checking bench for barrel_shifter_left_pipe (WIDTH = 8). Accepted
//   input beats push their expected result onto a scoreboard queue; emitted
//   output beats pop and compare.
module tb_barrel_shifter_left_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_shamt;
    logic         in_rotate;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_zero;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Values sampled on the falling edge of the most recent tick.
    logic         s_ready, s_valid, s_zero, s_acc, s_emit;
    logic [W-1:0] s_data;

    barrel_shifter_left_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_rotate (in_rotate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Reference: shift one bit at a time.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [2:0] s, input logic r);
        logic [W-1:0] x;
        x = d;
        for (int i = 0; i < int'(s); i++) begin
            x = {x[W-2:0], (r ? x[W-1] : 1'b0)};
        end
        return x;
    endfunction

    // One clock: drive inputs, sample at negedge, advance to posedge + 1.
    task automatic tick(input logic v, input logic [W-1:0] d, input logic [2:0] s,
                        input logic r, input logic ordy);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        in_shamt  = s;
        in_rotate = r;
        out_ready = ordy;
        @(negedge clk);
        s_ready = in_ready;
        s_valid = out_valid;
        s_data  = out_data;
        s_zero  = out_zero;
        s_acc   = v && in_ready;
        s_emit  = out_valid && ordy;
        if (s_acc) begin
            e.data = model(d, s, r);
            e.zero = (e.data == '0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 8'hFF, 3'd1, 1'b0, 1'b1);
            n_checks++;
            if (s_valid !== 1'b0 || s_data !== 8'h00 || s_zero !== 1'b0 || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: valid=%b data=%h zero=%b in_ready=%b, required 0 00 0 0",
                         s_valid, s_data, s_zero, s_ready);
            end
        end
        sb.delete();
        rst = 1'b0;
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (s_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: out_valid=%b in_ready=%b, required 0 1", s_valid, s_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] td [7] = '{8'h81, 8'h81, 8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'h10};
        logic [2:0]   ts [7] = '{3'd1, 3'd1, 3'd7, 3'd7, 3'd0, 3'd0, 3'd4};
        logic         tr [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] te [7] = '{8'h02, 8'h03, 8'h80, 8'hDA, 8'hB5, 8'hB5, 8'h00};
        logic         tz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            int  lat;
            logic got;
            tick(1'b1, td[i], ts[i], tr[i], 1'b1);
            n_checks++;
            if (s_acc !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_accept[%0d]: accepted=%b, required 1", i, s_acc);
            end
            got = 1'b0;
            lat = 0;
            for (int c = 1; c <= 6 && !got; c++) begin
                tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
                if (s_emit) begin
                    got = 1'b1;
                    lat = c;
                    if (sb.size() > 0) void'(sb.pop_front());
                    n_checks++;
                    if (s_data !== te[i] || s_zero !== tz[i]) begin
                        n_fail++;
                        $display("FAIL directed_data[%0d]: data=%h zero=%b, required %h %b",
                                 i, s_data, s_zero, te[i], tz[i]);
                    end
                end
            end
            n_checks++;
            if (!got || lat != 3) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got=%b latency=%0d, required 1 3", i, got, lat);
            end
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int sent = 0, early = 0, ne = 0, first = -1, last = -1;
        exp_t e;
        for (int c = 0; c < 20; c++) begin
            if (sent < 8) tick(1'b1, 8'(sent + 1), 3'd3, 1'b0, 1'b1);
            else          tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
            if (s_acc) begin
                sent++;
                if (c < 8) early++;
            end
            if (s_emit) begin
                if (first < 0) first = c;
                last = c;
                ne++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: data=%h, required no beat", s_data);
                end else begin
                    e = sb.pop_front();
                    if (s_data !== e.data || s_zero !== e.zero || s_data !== 8'(ne << 3)) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: data=%h zero=%b, required %h %b",
                                 ne, s_data, s_zero, e.data, e.zero);
                    end
                end
            end
        end
        n_checks++;
        if (early != 8 || ne != 8 || last - first != 7) begin
            n_fail++;
            $display("FAIL b2b_rate: accepts_in_8=%0d emits=%0d span=%0d, required 8 8 7",
                     early, ne, last - first);
        end
    endtask

    task automatic test_stall();
        int   nxt = 0, ne = 0;
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, 8'(8'h11 * (nxt + 1)), 3'(nxt + 1), nxt[0], 1'b0);
            if (s_acc) nxt++;
        end
        n_checks++;
        if (nxt != 3 || s_ready !== 1'b0 || s_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_fill: accepted=%0d in_ready=%b out_valid=%b, required 3 0 1",
                     nxt, s_ready, s_valid);
        end
        n_checks++;
        if (sb.size() == 0 || s_data !== sb[0].data) begin
            n_fail++;
            $display("FAIL stall_hold: data=%h, required head of queue (size %0d)", s_data, sb.size());
        end
        for (int c = 0; c < 40; c++) begin
            tick(nxt < 6, 8'(8'h11 * (nxt + 1)), 3'(nxt + 1), nxt[0], 1'b1);
            if (s_acc) nxt++;
            if (s_emit) begin
                ne++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_unexpected: data=%h, required no beat", s_data);
                end else begin
                    e = sb.pop_front();
                    if (s_data !== e.data || s_zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL stall_data[%0d]: data=%h zero=%b, required %h %b",
                                 ne, s_data, s_zero, e.data, e.zero);
                    end
                end
            end
        end
        n_checks++;
        if (nxt != 6 || ne != 6 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: accepted=%0d emitted=%0d left=%0d, required 6 6 0",
                     nxt, ne, sb.size());
        end
    endtask

    task automatic test_reset_flush();
        tick(1'b1, 8'h01, 3'd2, 1'b0, 1'b1);
        tick(1'b1, 8'h02, 3'd2, 1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b1, 8'h03, 3'd2, 1'b0, 1'b1);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: in_ready=%b during reset, required 0", s_ready);
        end
        sb.delete();
        rst = 1'b0;
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (s_valid !== 1'b0 || s_data !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_state: out_valid=%b out_data=%h, required 0 00", s_valid, s_data);
        end
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
            n_checks++;
            if (s_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale[%0d]: out_valid=%b data=%h, required 0", c, s_valid, s_data);
            end
        end
    endtask

    task automatic test_exhaustive();
        int   k = 0;
        logic v, ordy;
        exp_t e;
        for (int c = 0; c < 30000 && (k < 4096 || sb.size() > 0); c++) begin
            v    = (k < 4096) && ($urandom_range(3) != 0);
            ordy = (k >= 4096) || ($urandom_range(1) != 0);
            tick(v, k[7:0], k[10:8], k[11], ordy);
            if (s_acc) k++;
            if (s_emit) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL exh_unexpected: data=%h, required no beat", s_data);
                end else begin
                    e = sb.pop_front();
                    if (s_data !== e.data || s_zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL exh_data: data=%h zero=%b, required %h %b",
                                 s_data, s_zero, e.data, e.zero);
                    end
                end
            end
        end
        n_checks++;
        if (k != 4096 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL exh_complete: accepted=%0d left=%0d, required 4096 0", k, sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_rotate = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
